// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the data_sync bus synchronizer.
// Optional feature macro: DATA_SYNC_PARITY_EN (adds the sync_parity output).
package data_sync_pkg;

  localparam int DATA_SYNC_DEF_STAGES = 2;
  localparam int DATA_SYNC_DEF_WIDTH  = 8;
  localparam int DATA_SYNC_MIN_STAGES = 2;
  localparam int DATA_SYNC_MAX_STAGES = 8;
  localparam int DATA_SYNC_MAX_WIDTH  = 64;

  // True when a requested synchronizer depth is within the supported bounds.
  function automatic logic stages_in_range(input int n);
    return (n >= DATA_SYNC_MIN_STAGES) && (n <= DATA_SYNC_MAX_STAGES);
  endfunction

  // XOR reduction of a bus; narrower buses are zero-extended by the caller.
  function automatic logic bus_parity(input logic [DATA_SYNC_MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage : data_sync_pkg

// File: rtl/data_sync_chain.sv
// Single-bit multi-flop synchronizer chain, reusable for any level crossing.
// Stage 0 samples d, each later stage samples its predecessor, q is the last.
module sync_chain
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = DATA_SYNC_DEF_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] stage_r;

  generate
    if (!stages_in_range(NUM_STAGES)) begin : g_bad_stages
      $error("sync_chain: NUM_STAGES=%0d outside %0d..%0d",
             NUM_STAGES, DATA_SYNC_MIN_STAGES, DATA_SYNC_MAX_STAGES);
    end
  endgenerate

  // Shift the asynchronous input through the flop chain, no logic between stages.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stage_r <= {NUM_STAGES{1'b0}};
    end else begin
      stage_r <= {stage_r[NUM_STAGES-2:0], d};
    end
  end

  assign q = stage_r[NUM_STAGES-1];

endmodule : sync_chain

// File: rtl/data_sync.sv
// Bus synchronizer: a qualifier crosses via sync_chain, its rising edge loads
// the quasi-static source bus into a destination-domain register.
// Optional feature macro: DATA_SYNC_PARITY_EN adds sync_parity, the XOR of
// the loaded bus, updated and held together with sync_bus.
module data_sync
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = DATA_SYNC_DEF_STAGES,
  parameter int BUS_WIDTH  = DATA_SYNC_DEF_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
`ifdef DATA_SYNC_PARITY_EN
  output logic                 sync_parity,
`endif
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse_d
);

  logic en_sync_s;
  logic pulse_gen_r;
  logic enable_pulse_s;

  generate
    if (!stages_in_range(NUM_STAGES)) begin : g_bad_stages
      $error("data_sync: NUM_STAGES=%0d outside %0d..%0d",
             NUM_STAGES, DATA_SYNC_MIN_STAGES, DATA_SYNC_MAX_STAGES);
    end
    if ((BUS_WIDTH < 1) || (BUS_WIDTH > DATA_SYNC_MAX_WIDTH)) begin : g_bad_width
      $error("data_sync: BUS_WIDTH=%0d outside 1..%0d", BUS_WIDTH, DATA_SYNC_MAX_WIDTH);
    end
  endgenerate

  sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_enable_chain (
    .CLK (CLK),
    .RST (RST),
    .d   (bus_enable),
    .q   (en_sync_s)
  );

  // Remember the previous synchronized enable so only its rising edge counts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pulse_gen_r <= 1'b0;
    end else begin
      pulse_gen_r <= en_sync_s;
    end
  end

  assign enable_pulse_s = en_sync_s & ~pulse_gen_r;

  // Load the bus on the enable edge, otherwise recirculate; pulse follows the load.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_bus       <= {BUS_WIDTH{1'b0}};
      enable_pulse_d <= 1'b0;
    end else begin
      enable_pulse_d <= enable_pulse_s;
      if (enable_pulse_s) begin
        sync_bus <= unsync_bus;
      end else begin
        sync_bus <= sync_bus;
      end
    end
  end

`ifdef DATA_SYNC_PARITY_EN
  // Parity of the captured word, loaded and held in lockstep with sync_bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_parity <= 1'b0;
    end else if (enable_pulse_s) begin
      sync_parity <= bus_parity(DATA_SYNC_MAX_WIDTH'(unsync_bus));
    end else begin
      sync_parity <= sync_parity;
    end
  end
`endif

endmodule : data_sync

// File: tb/tb_data_sync.sv
// Self-checking bench for data_sync: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a sample-history model.
// Two instances share stimulus: depth 5 and depth 2, both 4 bits wide.
module tb_data_sync;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         bus_en;
  logic [W-1:0] data;
  logic [W-1:0] bus5, bus2;
  logic         pd5, pd2;
`ifdef DATA_SYNC_PARITY_EN
  logic         par5, par2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_sync #(.NUM_STAGES(5), .BUS_WIDTH(W)) dut5 (
    .CLK(clk), .RST(rst), .unsync_bus(data), .bus_enable(bus_en),
`ifdef DATA_SYNC_PARITY_EN
    .sync_parity(par5),
`endif
    .sync_bus(bus5), .enable_pulse_d(pd5)
  );

  data_sync #(.NUM_STAGES(2), .BUS_WIDTH(W)) dut2 (
    .CLK(clk), .RST(rst), .unsync_bus(data), .bus_enable(bus_en),
`ifdef DATA_SYNC_PARITY_EN
    .sync_parity(par2),
`endif
    .sync_bus(bus2), .enable_pulse_d(pd2)
  );

  // Reference model: per instance, a history of sampled enables (newest at 0).
  // A load happens when the sample taken N edges ago was high and the one
  // before it was low; reset wipes the whole history.
  int           depth [2] = '{5, 2};
  bit           hist  [2][0:9];
  logic [W-1:0] m_bus [2];
  logic         m_pd  [2];
  logic         m_par [2];

  task automatic model_step(input logic r, input logic e, input logic [W-1:0] d);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        for (int j = 0; j < 10; j++) hist[i][j] = 1'b0;
        m_bus[i] = '0;
        m_pd[i]  = 1'b0;
        m_par[i] = 1'b0;
      end else begin
        m_pd[i] = hist[i][depth[i]-1] && !hist[i][depth[i]];
        if (m_pd[i]) begin
          m_bus[i] = d;
          m_par[i] = ^d;
        end
        for (int j = 9; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = e;
      end
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, sample on the falling edge.
  task automatic tick(input logic r, input logic e, input logic [W-1:0] d);
    rst = r; bus_en = e; data = d;
    @(posedge clk);
    model_step(r, e, d);
    @(negedge clk);
  endtask

  typedef struct {
    logic         r;
    logic         e;
    logic [W-1:0] d;
    logic [W-1:0] exp_bus5;
    logic         exp_pd5;
    logic [W-1:0] exp_bus2;
    logic         exp_pd2;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int pulses;
    int p_at [2];
    logic e_r;
    logic r_r;
    logic [W-1:0] d_r;

    rst = 1'b1; bus_en = 1'b0; data = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 10; j++) hist[i][j] = 1'b0;
      m_bus[i] = '0; m_pd[i] = 1'b0; m_par[i] = 1'b0;
    end

    // Reset for two cycles, then a one-cycle enable at row 3 (edge k).
    // Depth 5 loads at k+5 (row 8); depth 2 loads at k+2 (row 5).
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'b1011, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 1'b0, 4'b1011, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 1'b0, 4'b1011, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b1011, 4'b0000, 1'b0, 4'b1011, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'b1011, 4'b1011, 1'b1, 4'b1011, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'b1011, 4'b1011, 1'b0, 4'b1011, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'b1011, 4'b1011, 1'b0, 4'b1011, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].d);
      chk($sformatf("table%0d_bus5", i), bus5, tbl[i].exp_bus5);
      chk($sformatf("table%0d_pd5", i), {3'b000, pd5}, {3'b000, tbl[i].exp_pd5});
      chk($sformatf("table%0d_bus2", i), bus2, tbl[i].exp_bus2);
      chk($sformatf("table%0d_pd2", i), {3'b000, pd2}, {3'b000, tbl[i].exp_pd2});
    end
`ifdef DATA_SYNC_PARITY_EN
    chk("parity5_1011", {3'b000, par5}, 4'b0001);
    chk("parity2_1011", {3'b000, par2}, 4'b0001);
`endif

    // Long enable: ten high cycles give one pulse; later bus changes are ignored.
    tick(1'b1, 1'b0, 4'b1011);
    tick(1'b1, 1'b0, 4'b1011);
    pulses = 0;
    for (int t = 0; t < 20; t++) begin
      tick(1'b0, (t < 10), 4'b1011);
      if (pd5) pulses++;
    end
    for (int t = 0; t < 10; t++) begin
      tick(1'b0, 1'b0, 4'b0100);
      if (pd5) pulses++;
    end
    chk("long_enable_pulses", 4'(pulses), 4'd1);
    chk("long_enable_hold", bus5, 4'b1011);

    // Two transfers, enables three low cycles apart.
    tick(1'b1, 1'b0, 4'b0000);
    tick(1'b1, 1'b0, 4'b0000);
    pulses = 0; p_at[0] = -1; p_at[1] = -1;
    for (int t = 0; t < 16; t++) begin
      tick(1'b0, (t == 0) || (t == 4), (t < 4) ? 4'b1011 : 4'b0110);
      if (pd5) begin
        if (pulses < 2) p_at[pulses] = t;
        pulses++;
      end
    end
    chk("two_xfer_pulses", 4'(pulses), 4'd2);
    chk("two_xfer_first_at", 4'(p_at[0]), 4'd5);
    chk("two_xfer_second_at", 4'(p_at[1]), 4'd9);
    chk("two_xfer_final_bus", bus5, 4'b0110);

    // Reset two edges after the enable sample: the transfer is dropped.
    tick(1'b1, 1'b0, 4'b1011);
    tick(1'b1, 1'b0, 4'b1011);
    pulses = 0;
    for (int t = 0; t <= 12; t++) begin
      tick((t == 2), (t == 0), 4'b1011);
      if (pd5) pulses++;
    end
    chk("reset_midflight_pulses", 4'(pulses), 4'd0);
    chk("reset_midflight_bus", bus5, 4'b0000);

    // Randomized traffic against the model on both depths.
    e_r = 1'b0;
    d_r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      r_r = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 4) == 0) e_r = ~e_r;
      if ($urandom_range(0, 3) == 0) d_r = 4'($urandom);
      tick(r_r, e_r, d_r);
      chk("rand_bus5", bus5, m_bus[0]);
      chk("rand_pd5", {3'b000, pd5}, {3'b000, m_pd[0]});
      chk("rand_bus2", bus2, m_bus[1]);
      chk("rand_pd2", {3'b000, pd2}, {3'b000, m_pd[1]});
`ifdef DATA_SYNC_PARITY_EN
      chk("rand_par5", {3'b000, par5}, {3'b000, m_par[0]});
      chk("rand_par2", {3'b000, par2}, {3'b000, m_par[1]});
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_data_sync
